// File: rtl/prim_xilinx_reg_reader.sv
// Snapshots a Width-bit register on request and streams it LSB-first as
// ChunkW-bit beats over a valid/ready handshake, pulsing done_o after the last beat.
module prim_xilinx_reg_reader #(
  parameter  int Width     = 32,
  parameter  int ChunkW    = 8,
  localparam int NumChunks = (Width + ChunkW - 1) / ChunkW,
  localparam int IdxW      = (NumChunks > 1) ? $clog2(NumChunks) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic [Width-1:0]  data_i,
  output logic              busy_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ChunkW-1:0] chunk_o,
  output logic [IdxW-1:0]   idx_o,
  output logic              last_o,
  output logic              done_o
);

  // state | meaning
  // IDLE  | waiting for req_i; snapshot is captured on the accepting edge
  // SEND  | presenting snapshot slice idx_q with valid_o held until accepted
  typedef enum logic {IDLE, SEND} state_e;

  localparam int            PadW    = NumChunks * ChunkW;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

  if (ChunkW < 1 || ChunkW > Width) begin : g_bad_chunkw
    $error("prim_xilinx_reg_reader: ChunkW must be in 1..Width");
  end

  state_e            state_q, state_d;
  logic [PadW-1:0]   snap_q, snap_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic [PadW-1:0]   snap_shifted;
  logic              at_last;

  assign at_last      = (idx_q == LastIdx);
  assign snap_shifted = snap_q >> (idx_q * ChunkW);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          // Zero-extension pads the final slice when Width is not a multiple of ChunkW.
          snap_d  = PadW'(data_i);
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (ready_i) begin
          if (at_last) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == SEND);
    valid_o = (state_q == SEND);
    chunk_o = (state_q == SEND) ? snap_shifted[ChunkW-1:0] : '0;
    idx_o   = idx_q;
    last_o  = (state_q == SEND) && at_last;
    done_o  = done_q;
  end

  a_stall_stable : assert property (@(posedge clk_i)
    (rst_ni && valid_o && !ready_i) |=> (valid_o && $stable(chunk_o)));

  a_done_single : assert property (@(posedge clk_i) done_o |=> !done_o);

endmodule
